// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU in EX.
// Quotient goes to LO and remainder to HI. stall_o holds the upstream
// pipeline registers while a division is being accepted or iterated.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             DIV/DIVU present in EX (held until ready)
//   signed_div        1 = DIV (two's complement), 0 = DIVU
//   annul             flush the operation; wins over start
//   a, b              dividend / divisor, sampled on the accept cycle
//   stall_o           combinational stall request
//   ready             registered, results valid this cycle
//   lo_o, hi_o        registered quotient / remainder
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic             annul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall_o,
  output logic             ready,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic             q_neg;
  logic             r_neg;

  logic             accept;
  logic             div_zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] quo_fin;
  logic [WIDTH-1:0] rem_fin;

  // Operand magnitudes; the most negative value maps onto itself, which is
  // the correct unsigned magnitude.
  always_comb begin
    a_mag    = (signed_div && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    b_mag    = (signed_div && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    accept   = (state == IDLE) && start && !annul;
    div_zero = (b == '0);
    stall_o  = accept || (state == BUSY);
  end

  // One restoring step. rem < dvs always holds, so WIDTH+1 bits suffice and
  // diff's top bit is the borrow.
  always_comb begin
    shifted = {rem, dvd[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    rem_nxt = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    quo_nxt = {dvd[WIDTH-2:0], ~diff[WIDTH]};
    quo_fin = q_neg ? (~quo_nxt + WIDTH'(1)) : quo_nxt;
    rem_fin = r_neg ? (~rem_nxt + WIDTH'(1)) : rem_nxt;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; annul returns to IDLE from any state.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = div_zero ? DONE : BUSY;
      BUSY: if (cnt == CNT_LAST) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (annul) state_next = IDLE;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      ready <= 1'b0;
      lo_o  <= '0;
      hi_o  <= '0;
    end else begin
      ready <= (state_next == DONE);
      if (accept) begin
        dvd   <= a_mag;
        dvs   <= b_mag;
        rem   <= '0;
        cnt   <= '0;
        q_neg <= signed_div && (a[WIDTH-1] ^ b[WIDTH-1]);
        r_neg <= signed_div && a[WIDTH-1];
        if (div_zero) begin
          lo_o <= '1;
          hi_o <= a;
        end
      end else if ((state == BUSY) && !annul) begin
        dvd <= quo_nxt;
        rem <= rem_nxt;
        cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_LAST) begin
          lo_o <= quo_fin;
          hi_o <= rem_fin;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed bench for div_unit with hand-computed results.
module tb_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic        annul;
  logic [31:0] a;
  logic [31:0] b;
  logic        stall_o;
  logic        ready;
  logic [31:0] lo_o;
  logic [31:0] hi_o;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .annul      (annul),
    .a          (a),
    .b          (b),
    .stall_o    (stall_o),
    .ready      (ready),
    .lo_o       (lo_o),
    .hi_o       (hi_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge with the DUT idle; leaves 1 time unit after the
  // negedge of cycle t+34.
  task automatic run_div(input logic [31:0] av, input logic [31:0] bv, input logic sd,
                         input logic [31:0] elo, input logic [31:0] ehi, input string tag);
    a = av; b = bv; signed_div = sd; start = 1'b1;
    #1;
    chk({tag, " stall@t"}, 32'(stall_o), 32'd1);
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk); #1;
      chk($sformatf("%s stall@t+%0d", tag, i), 32'(stall_o), 32'd1);
      chk($sformatf("%s ready@t+%0d", tag, i), 32'(ready), 32'd0);
    end
    @(negedge clk); #1;
    chk({tag, " ready@t+33"}, 32'(ready), 32'd1);
    chk({tag, " lo"}, lo_o, elo);
    chk({tag, " hi"}, hi_o, ehi);
    chk({tag, " stall@done"}, 32'(stall_o), 32'd0);
    start = 1'b0;
    @(negedge clk); #1;
    chk({tag, " idle@t+34"}, 32'(dut.state), 32'd0);
    chk({tag, " ready@t+34"}, 32'(ready), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; signed_div = 1'b0; annul = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset ready", 32'(ready), 32'd0);
    chk("reset lo", lo_o, 32'd0);
    chk("reset hi", hi_o, 32'd0);
    chk("reset stall", 32'(stall_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_div(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, "udiv_100_7");
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "sdiv_m7_2");
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, "sdiv_7_m2");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, "sdiv_ovf");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, "udiv_ext");

    // Divide by zero: single stall cycle, result next cycle.
    a = 32'd5; b = 32'd0; signed_div = 1'b0; start = 1'b1;
    #1;
    chk("div0 stall@t", 32'(stall_o), 32'd1);
    @(negedge clk); #1;
    chk("div0 ready@t+1", 32'(ready), 32'd1);
    chk("div0 lo", lo_o, 32'hFFFF_FFFF);
    chk("div0 hi", hi_o, 32'd5);
    chk("div0 stall@t+1", 32'(stall_o), 32'd0);
    start = 1'b0;
    @(negedge clk); #1;
    chk("div0 ready@t+2", 32'(ready), 32'd0);
    chk("div0 idle@t+2", 32'(dut.state), 32'd0);

    // Annul at t+10: no result, outputs keep the divide-by-zero values.
    a = 32'd100; b = 32'd7; signed_div = 1'b0; start = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk); #1;
      chk($sformatf("annul ready@t+%0d", i), 32'(ready), 32'd0);
    end
    annul = 1'b1;
    @(negedge clk);
    annul = 1'b0; start = 1'b0;
    #1;
    chk("annul idle@t+11", 32'(dut.state), 32'd0);
    chk("annul ready@t+11", 32'(ready), 32'd0);
    chk("annul lo kept", lo_o, 32'hFFFF_FFFF);
    chk("annul hi kept", hi_o, 32'd5);
    @(negedge clk);
    run_div(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, "post_annul_9_3");

    // Reset asserted during cycle t+5 of a divide.
    a = 32'd100; b = 32'd7; signed_div = 1'b0; start = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    #1;
    chk("rst ready@t+6", 32'(ready), 32'd0);
    chk("rst lo@t+6", lo_o, 32'd0);
    chk("rst hi@t+6", hi_o, 32'd0);
    chk("rst stall@t+6", 32'(stall_o), 32'd0);
    chk("rst idle@t+6", 32'(dut.state), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 integer divider for the EX stage of the MIPS pipeline. It executes DIV and DIVU, producing a quotient for LO and a remainder for HI. While a division is in flight it drives `stall_o`, which deasserts the enables of the upstream PC and pipeline `flopenr` registers and freezes IF/ID/EX. Its registered `lo_o`/`hi_o` outputs feed the HI/LO write path downstream.

## Interface
- `WIDTH`, default 32: operand and result width.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: a DIV/DIVU is in EX. Held high by the stalled pipeline until `ready` is returned.
- `signed_div` in 1: 1 = DIV (two's complement), 0 = DIVU.
- `annul` in 1: flushes the operation (exception or flush); has priority over `start`.
- `a` in WIDTH: dividend. Sampled only on the accept cycle.
- `b` in WIDTH: divisor. Sampled only on the accept cycle.
- `stall_o` out 1: combinational pipeline stall request.
- `ready` out 1: registered; results valid this cycle.
- `lo_o` out WIDTH: registered quotient.
- `hi_o` out WIDTH: registered remainder.

## Operation
- FSM states are IDLE, BUSY and DONE. Reset forces IDLE, a cleared counter, `ready=0`, `lo_o=0` and `hi_o=0`.
- IDLE with `start=1` and `annul=0` is the accept cycle. On this edge the unit:
  - latches |a|, |b| (magnitudes when `signed_div=1`, raw values otherwise);
  - latches the quotient sign (sign(a) XOR sign(b)) and the remainder sign (sign(a));
  - clears the partial remainder and counter.
- If `b==0` on the accept cycle, the next state is DONE with `lo_o={WIDTH{1}}` and `hi_o=a` (raw bits); no iteration is performed. Otherwise the next state is BUSY.
- BUSY performs one restoring step per cycle:
  - shift {rem, dividend} left by 1;
  - trial subtract the divisor on WIDTH+1 bits;
  - if the result is non-negative, keep it and set quotient bit = 1; else set quotient bit = 0.
  - After WIDTH steps (counter == WIDTH-1), go to DONE.
- Entering DONE loads `lo_o`/`hi_o`:
  - quotient is negated when the quotient sign is 1;
  - remainder is negated when the remainder sign is 1;
  - both signs are 0 for DIVU.
- DONE always returns to IDLE on the next edge and ignores `start`; `start` is still high there for the same instruction.
- `lo_o`/`hi_o` hold their value until the next DONE entry or reset.
- `annul=1` in any state sends the FSM to IDLE on the next edge. In that case `ready` is not asserted and `lo_o`/`hi_o` keep their previous values.
- The overflow case 0x80000000 / 0xFFFFFFFF (signed) gives `lo_o=0x80000000`, `hi_o=0`, with no trap.
- `rst` mid-operation overrides everything and takes effect on the next edge.

## Timing
- `stall_o = (IDLE & start & ~annul) | BUSY`. It is combinational so the accept cycle itself stalls the pipeline.
- Normal divide with the accept cycle at t:
  - BUSY during cycles t+1 .. t+WIDTH;
  - DONE at t+WIDTH+1, with `ready=1` for exactly one cycle;
  - `stall_o` is high during t .. t+WIDTH (WIDTH+1 cycles, 33 at default) and low in DONE, so the pipeline advances in that cycle.
- Divide by zero: `stall_o` is high at t only; DONE/`ready` at t+1.
- Back-to-back divides: the second `start` is accepted no earlier than the IDLE cycle at t+WIDTH+2.
- `ready` is never high in two consecutive cycles.

## Test plan
- Unsigned: accept `a=100`, `b=7`, `signed_div=0` at t.
  - Required: `stall_o` high t..t+32.
  - Required: `ready` at t+33 with `lo_o=14`, `hi_o=2`.
  - Required: IDLE at t+34.
- Signed negative: `a=0xFFFFFFF9` (-7), `b=2`, `signed_div=1`.
  - Required: `lo_o=0xFFFFFFFD`, `hi_o=0xFFFFFFFF`.
  - Repeat with `a=7`, `b=0xFFFFFFFE`. Required: `lo_o=0xFFFFFFFD`, `hi_o=1`.
- Signed overflow and unsigned extreme:
  - `a=0x80000000`, `b=0xFFFFFFFF`, `signed_div=1`. Required: `lo_o=0x80000000`, `hi_o=0`.
  - Same operands with `signed_div=0`. Required: `lo_o=0`, `hi_o=0x80000000`.
- Divide by zero: `a=5`, `b=0`.
  - Required: `stall_o` high only at t.
  - Required: `ready` at t+1 with `lo_o=0xFFFFFFFF`, `hi_o=5`.
- Annul mid-operation:
  - Start 100/7, then pulse `annul` at t+10. Required: IDLE at t+11, `ready` never asserted, `lo_o`/`hi_o` unchanged.
  - Then start 9/3 at t+12. Required: `ready` at t+45 with `lo_o=3`, `hi_o=0`.
- Reset mid-operation: assert `rst` at t+5.
  - Required at t+6: `ready=0`, `lo_o=0`, `hi_o=0`.
  - Required at t+6: `stall_o=0` while `start=0`.
